// File: rtl/relogio_pkg.sv
// Shared constants and types for the clock counter family.
//
// Holds the moduli used by the second, minute and hour stages together with
// the counter width each one needs, the width of the BCD converter input, and
// the per-edge operation type used by contador_mod.
//
// No ports (package).
package relogio_pkg;

  localparam int SEG_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HORA_MOD = 24;

  localparam int SEG_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HORA_W = 5;

  // Widest count the BCD converter handles (MODULO tops out at 100).
  localparam int BCD_IN_W = 7;

  // What the counter does at the next rising edge, once reset is excluded.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_LOAD_ERR,
    OP_INC,
    OP_DEC
  } cnt_op_e;

  // Priority: load > increment-only > decrement-only > hold.
  // inc and dec together cancel, and en gates only inc/dec, never load.
  function automatic cnt_op_e decode_op(input logic load,
                                        input logic load_ok,
                                        input logic en,
                                        input logic inc,
                                        input logic dec);
    cnt_op_e op;
    op = OP_HOLD;
    if (load) begin
      op = load_ok ? OP_LOAD : OP_LOAD_ERR;
    end else if (en && inc && !dec) begin
      op = OP_INC;
    end else if (en && dec && !inc) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/contador_mod_bin2bcd.sv
// Binary to two-digit BCD converter.
//
// Purely combinational. Inputs up to 99 produce a valid digit pair; the
// counter that feeds it never goes above 99.
//
// Ports:
//   bin    in   7  binary value
//   tens   out  4  bin / 10
//   units  out  4  bin mod 10
module bin2bcd
  import relogio_pkg::*;
(
  input  logic [BCD_IN_W-1:0] bin,
  output logic [3:0]          tens,
  output logic [3:0]          units
);

  // Constant divisors; synthesis reduces these to small lookup logic.
  always_comb begin
    tens  = 4'(bin / 7'd10);
    units = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/contador_mod.sv
// Modulo-N up/down counter with load, wrap pulses and BCD digit outputs.
//
// Counts 0..MODULO-1. Wrap pulses (carry_o, borrow_o) and the rejected-load
// pulse (load_err_o) are registered alongside count_o, so each appears in the
// same cycle as the count value it describes. Feeding carry_o into the next
// stage's inc_i therefore cascades with one cycle of delay per stage.
//
// Ports:
//   clk_i       in   1      clock, rising edge
//   rstn_i      in   1      synchronous active-low reset
//   en_i        in   1      enable for inc_i/dec_i (load_i is not gated)
//   inc_i       in   1      increment request, one step per high cycle
//   dec_i       in   1      decrement request, one step per high cycle
//   load_i      in   1      load strobe
//   load_val_i  in   WIDTH  value to load; values >= MODULO are rejected
//   count_o     out  WIDTH  registered count
//   tens_o      out  4      BCD tens digit of count_o
//   units_o     out  4      BCD units digit of count_o
//   carry_o     out  1      one-cycle pulse on wrap MODULO-1 -> 0
//   borrow_o    out  1      one-cycle pulse on wrap 0 -> MODULO-1
//   load_err_o  out  1      one-cycle pulse on rejected load
module contador_mod
  import relogio_pkg::*;
#(
  parameter int MODULO    = HORA_MOD,
  parameter int WIDTH     = HORA_W,
  parameter int RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       units_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             load_err_o
);

  // Parameter sanity: refuse to elaborate a counter that cannot work.
  if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
    $error("contador_mod: MODULO must be within 2..100");
  end
  if ((64'd1 << WIDTH) < 64'(MODULO)) begin : g_bad_width
    $error("contador_mod: WIDTH too small for MODULO");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset
    $error("contador_mod: RESET_VAL must be below MODULO");
  end

  // MODULO itself may not fit in WIDTH bits (e.g. 32 in 5 bits), but
  // MODULO-1 always does, so every bound is expressed against it.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  cnt_op_e          op;
  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic             borrow_q;
  logic             load_err_q;

  always_comb begin
    op = decode_op(load_i, (load_val_i <= MAX_VAL), en_i, inc_i, dec_i);
  end

  // Pulses default low every edge, so each lasts exactly one cycle and a
  // reset edge clears any pulse that would otherwise have appeared.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q    <= RST_VAL;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      case (op)
        OP_LOAD: begin
          count_q <= load_val_i;
        end
        OP_LOAD_ERR: begin
          load_err_q <= 1'b1;
        end
        OP_INC: begin
          if (count_q == MAX_VAL) begin
            count_q <= '0;
            carry_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        OP_DEC: begin
          if (count_q == '0) begin
            count_q  <= MAX_VAL;
            borrow_q <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count_o    = count_q;
  assign carry_o    = carry_q;
  assign borrow_o   = borrow_q;
  assign load_err_o = load_err_q;

  bin2bcd u_bcd (
    .bin   (BCD_IN_W'(count_q)),
    .tens  (tens_o),
    .units (units_o)
  );

endmodule

// File: tb/tb_contador_mod.sv
// Testbench for contador_mod: a standalone MODULO=24 counter plus a
// MODULO=60 -> MODULO=24 cascade through carry_o. A modular-arithmetic model
// tracks all three counters and is compared on every falling edge; directed
// checks pin specific values.
module tb_contador_mod;
  import relogio_pkg::*;

  localparam int M   = HORA_MOD;
  localparam int RV  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              en = 0, inc = 0, dec = 0, load = 0;
  logic [HORA_W-1:0] load_val = '0;
  logic [HORA_W-1:0] count;
  logic [3:0]        tens, units;
  logic              carry, borrow, load_err;

  logic              s_en = 0, s_inc = 0, s_dec = 0, s_load = 0;
  logic [SEG_W-1:0]  s_load_val = '0;
  logic [SEG_W-1:0]  s_count;
  logic [3:0]        s_tens, s_units;
  logic              s_carry, s_borrow, s_err;

  logic              h_load = 0;
  logic [HORA_W-1:0] h_load_val = '0;
  logic [HORA_W-1:0] h_count;
  logic [3:0]        h_tens, h_units;
  logic              h_carry, h_borrow, h_err;

  contador_mod #(.MODULO(M), .WIDTH(HORA_W), .RESET_VAL(RV)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .inc_i(inc), .dec_i(dec),
    .load_i(load), .load_val_i(load_val), .count_o(count), .tens_o(tens),
    .units_o(units), .carry_o(carry), .borrow_o(borrow), .load_err_o(load_err)
  );

  contador_mod #(.MODULO(SEG_MOD), .WIDTH(SEG_W), .RESET_VAL(0)) u_sec (
    .clk_i(clk), .rstn_i(rstn), .en_i(s_en), .inc_i(s_inc), .dec_i(s_dec),
    .load_i(s_load), .load_val_i(s_load_val), .count_o(s_count),
    .tens_o(s_tens), .units_o(s_units), .carry_o(s_carry),
    .borrow_o(s_borrow), .load_err_o(s_err)
  );

  contador_mod #(.MODULO(HORA_MOD), .WIDTH(HORA_W), .RESET_VAL(0)) u_hr (
    .clk_i(clk), .rstn_i(rstn), .en_i(1'b1), .inc_i(s_carry), .dec_i(1'b0),
    .load_i(h_load), .load_val_i(h_load_val), .count_o(h_count),
    .tens_o(h_tens), .units_o(h_units), .carry_o(h_carry),
    .borrow_o(h_borrow), .load_err_o(h_err)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counter as an integer modulo m; pulses derived from whether the step
  // crossed the wrap point.
  task automatic model_step(input int m, input int cnt, input bit rst_n,
                            input bit ld, input int lv, input bit e,
                            input bit up, input bit dn, output int n,
                            output bit c, output bit b, output bit err);
    n = cnt; c = 0; b = 0; err = 0;
    if (!rst_n) begin
      n = RV;
    end else if (ld) begin
      if (lv < m) n = lv;
      else err = 1;
    end else if (e && up && !dn) begin
      n = (cnt + 1) % m;
      c = (cnt + 1 == m);
    end else if (e && dn && !up) begin
      n = (cnt + m - 1) % m;
      b = (cnt == 0);
    end
  endtask

  int m_cnt = 0, m_s = 0, m_h = 0;
  bit m_c, m_b, m_e, ms_c, ms_b, ms_e, mh_c, mh_b, mh_e;
  bit model_on = 0;

  always @(posedge clk) begin
    bit prev_s_carry;
    prev_s_carry = ms_c;
    model_step(M, m_cnt, rstn, load, int'(load_val), en, inc, dec,
               m_cnt, m_c, m_b, m_e);
    model_step(SEG_MOD, m_s, rstn, s_load, int'(s_load_val), s_en, s_inc,
               s_dec, m_s, ms_c, ms_b, ms_e);
    model_step(HORA_MOD, m_h, rstn, h_load, int'(h_load_val), 1'b1,
               prev_s_carry, 1'b0, m_h, mh_c, mh_b, mh_e);
    model_on = 1;
  end

  // Compare process: every falling edge once the model is live.
  always @(negedge clk) begin
    if (model_on) begin
      cmp("count",    int'(count),    m_cnt);
      cmp("tens",     int'(tens),     m_cnt / 10);
      cmp("units",    int'(units),    m_cnt % 10);
      cmp("carry",    int'(carry),    int'(m_c));
      cmp("borrow",   int'(borrow),   int'(m_b));
      cmp("load_err", int'(load_err), int'(m_e));
      cmp("s_count",  int'(s_count),  m_s);
      cmp("s_bcd",    int'(s_tens) * 10 + int'(s_units), m_s);
      cmp("s_pulses", {s_carry, s_borrow, s_err}, {ms_c, ms_b, ms_e});
      cmp("h_count",  int'(h_count),  m_h);
      cmp("h_bcd",    int'(h_tens) * 10 + int'(h_units), m_h);
      cmp("h_pulses", {h_carry, h_borrow, h_err}, {mh_c, mh_b, mh_e});
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    // Reset state
    cmp("rst_count", int'(count), RV);
    cmp("rst_pulses", {carry, borrow, load_err}, 0);
    rstn = 1;

    // Full up-count with wrap
    en = 1; inc = 1;
    for (int i = 0; i < M; i++) begin
      cmp("up_count", int'(count), i);
      cmp("up_carry", int'(carry), 0);
      tick();
      if (i == M - 2) begin
        cmp("bcd_23", int'(tens) * 10 + int'(units), 23);
        cmp("tens_23", int'(tens), 2);
        cmp("units_23", int'(units), 3);
      end
    end
    cmp("wrap_count", int'(count), 0);
    cmp("wrap_carry", int'(carry), 1);
    inc = 0;
    tick();
    cmp("carry_one_cycle", int'(carry), 0);

    // Down-wrap
    dec = 1;
    tick();
    cmp("dwrap_count", int'(count), 23);
    cmp("dwrap_borrow", int'(borrow), 1);
    tick();
    cmp("dec_count", int'(count), 22);
    cmp("dec_borrow", int'(borrow), 0);
    dec = 0;

    // Loads: accepted and rejected
    load = 1; load_val = 17;
    tick();
    cmp("load17_count", int'(count), 17);
    cmp("load17_bcd", {tens, units}, {4'd1, 4'd7});
    load_val = 24;
    tick();
    cmp("badload_count", int'(count), 17);
    cmp("badload_err", int'(load_err), 1);
    load = 0;
    tick();
    cmp("err_one_cycle", int'(load_err), 0);

    // Load beats simultaneous increment at the wrap point
    load = 1; load_val = 23;
    tick();
    load_val = 5; inc = 1;
    tick();
    cmp("load_over_inc", int'(count), 5);
    cmp("load_no_carry", int'(carry), 0);
    load = 0; dec = 1;
    tick();
    cmp("incdec_hold", int'(count), 5);
    cmp("incdec_nopulse", {carry, borrow, load_err}, 0);
    // Enable low: hold, load still honoured
    en = 0; dec = 0;
    tick();
    cmp("en_low_hold", int'(count), 5);
    load = 1; load_val = 9;
    tick();
    cmp("en_low_load", int'(count), 9);
    load = 0; inc = 0;

    // Cascade seconds -> hours
    s_load = 1; s_load_val = 59; h_load = 1; h_load_val = 23;
    tick();
    cmp("chain_load", int'(s_count) * 100 + int'(h_count), 5923);
    s_load = 0; h_load = 0; s_en = 1; s_inc = 1;
    tick();
    s_inc = 0;
    cmp("chain_s0", int'(s_count) * 100 + int'(h_count), 23);
    cmp("chain_s_carry", int'(s_carry), 1);
    tick();
    cmp("chain_h0", int'(s_count) * 100 + int'(h_count), 0);
    cmp("chain_h_carry", int'(h_carry), 1);
    tick();
    cmp("chain_h_carry_off", int'(h_carry), 0);

    // Reset overrides increment at 23
    load = 1; load_val = 23;
    tick();
    load = 0; en = 1; inc = 1; rstn = 0;
    tick();
    cmp("rst_over_inc", int'(count), RV);
    cmp("rst_no_carry", int'(carry), 0);
    rstn = 1;
    tick();
    cmp("after_rst", int'(count), RV + 1);

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      inc = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 9) == 0);
      load_val = HORA_W'($urandom_range(0, 31));
      s_en = 1;
      s_inc = 1'($urandom_range(0, 3) != 0);
      s_dec = 1'($urandom_range(0, 7) == 0);
      s_load = 1'($urandom_range(0, 15) == 0);
      s_load_val = SEG_W'($urandom_range(50, 63));
      h_load = 1'($urandom_range(0, 15) == 0);
      h_load_val = HORA_W'($urandom_range(20, 31));
      rstn = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
